// File: rtl/gpio_port_pcint.sv
// gpio_port_pcint
// ---------------------------------------------------------------------------
// AVR-style GPIO port with PORTx / DDRx / PINx registers, a multi-stage input
// synchroniser, a per-bit glitch filter and per-bit pin-change interrupt
// flags (PCMSK / PCIF). One instance serves one port.
//
// Parameters:
//   WIDTH          pins in the port (1..32)
//   SYNC_STAGES    synchroniser flops per pin (2..4)
//   FILTER_CYCLES  consecutive differing synchronised samples needed before
//                  the filtered value follows the input (1..255, 1 = none)
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-high reset, clears every flop
//   bus_addr      register select: 0 PIN, 1 DDR, 2 PORT, 3 PCMSK, 4 PCIF
//   bus_we        single-cycle write strobe
//   bus_re        single-cycle read strobe
//   bus_wdata     write data
//   bus_rdata     registered read data (holds when bus_rvalid = 0)
//   bus_rvalid    one cycle after bus_re, marks bus_rdata valid
//   gpio_pin_in   asynchronous pad inputs
//   gpio_pin_out  PORT register
//   gpio_pin_dir  DDR register, 1 = output
//   irq           OR of all PCIF bits
// ---------------------------------------------------------------------------
module gpio_port_pcint #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       bus_addr,
    input  logic             bus_we,
    input  logic             bus_re,
    input  logic [WIDTH-1:0] bus_wdata,
    output logic [WIDTH-1:0] bus_rdata,
    output logic             bus_rvalid,
    input  logic [WIDTH-1:0] gpio_pin_in,
    output logic [WIDTH-1:0] gpio_pin_out,
    output logic [WIDTH-1:0] gpio_pin_dir,
    output logic             irq
);

    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    localparam logic [2:0] ADDR_PIN   = 3'd0;
    localparam logic [2:0] ADDR_DDR   = 3'd1;
    localparam logic [2:0] ADDR_PORT  = 3'd2;
    localparam logic [2:0] ADDR_PCMSK = 3'd3;
    localparam logic [2:0] ADDR_PCIF  = 3'd4;

    logic [WIDTH-1:0] sync_out;
    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] toggle;

    logic [WIDTH-1:0] ddr_reg;
    logic [WIDTH-1:0] port_reg;
    logic [WIDTH-1:0] pcmsk_reg;
    logic [WIDTH-1:0] pcif_reg;
    logic [WIDTH-1:0] pcif_next;
    logic [WIDTH-1:0] pcif_clr;
    logic [WIDTH-1:0] rdata_reg;
    logic             rvalid_reg;
    logic [WIDTH-1:0] rd_mux;

    genvar gi;

    // -----------------------------------------------------------------------
    // Synchroniser: a plain shift chain, one vector per stage.
    // -----------------------------------------------------------------------
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
        logic [WIDTH-1:0] stage_reg;
        if (gi == 0) begin : g_first
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= gpio_pin_in;
                end
            end
        end else begin : g_next
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    stage_reg <= '0;
                end else begin
                    stage_reg <= g_sync[gi-1].stage_reg;
                end
            end
        end
    end

    assign sync_out = g_sync[SYNC_STAGES-1].stage_reg;

    // -----------------------------------------------------------------------
    // Glitch filter: each bit counts consecutive samples that disagree with
    // the filtered value; any agreeing sample restarts the count, so only a
    // run of FILTER_CYCLES differing samples moves the filtered value.
    // toggle marks the edge on which the filtered bit flips.
    // -----------------------------------------------------------------------
    for (gi = 0; gi < WIDTH; gi++) begin : g_filt
        logic             bit_reg;
        logic [CNT_W-1:0] cnt_reg;
        logic             differs;

        assign differs = (sync_out[gi] != bit_reg);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                bit_reg <= 1'b0;
                cnt_reg <= '0;
            end else if (!differs) begin
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_LAST) begin
                bit_reg <= sync_out[gi];
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end

        assign filt[gi]   = bit_reg;
        assign toggle[gi] = differs && (cnt_reg == CNT_LAST);
    end

    // -----------------------------------------------------------------------
    // Pin-change flags: a masked toggle sets the flag; write-1 clears it.
    // The set term is ORed in last so a same-cycle set beats the clear.
    // -----------------------------------------------------------------------
    always_comb begin
        pcif_clr = '0;
        if (bus_we && (bus_addr == ADDR_PCIF)) begin
            pcif_clr = bus_wdata;
        end
        pcif_next = (pcif_reg & ~pcif_clr) | (toggle & pcmsk_reg);
    end

    // Read mux uses current register values, so a read coinciding with a
    // write returns the pre-write contents.
    always_comb begin
        rd_mux = '0;
        case (bus_addr)
            ADDR_PIN:   rd_mux = filt;
            ADDR_DDR:   rd_mux = ddr_reg;
            ADDR_PORT:  rd_mux = port_reg;
            ADDR_PCMSK: rd_mux = pcmsk_reg;
            ADDR_PCIF:  rd_mux = pcif_reg;
            default:    rd_mux = '0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Register file and read port.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ddr_reg    <= '0;
            port_reg   <= '0;
            pcmsk_reg  <= '0;
            pcif_reg   <= '0;
            rdata_reg  <= '0;
            rvalid_reg <= 1'b0;
        end else begin
            pcif_reg   <= pcif_next;
            rvalid_reg <= bus_re;
            if (bus_re) begin
                rdata_reg <= rd_mux;
            end
            if (bus_we) begin
                case (bus_addr)
                    // Writing ones to PIN toggles the matching PORT bits.
                    ADDR_PIN:   port_reg  <= port_reg ^ bus_wdata;
                    ADDR_DDR:   ddr_reg   <= bus_wdata;
                    ADDR_PORT:  port_reg  <= bus_wdata;
                    ADDR_PCMSK: pcmsk_reg <= bus_wdata;
                    default:    ;
                endcase
            end
        end
    end

    assign bus_rdata    = rdata_reg;
    assign bus_rvalid   = rvalid_reg;
    assign gpio_pin_out = port_reg;
    assign gpio_pin_dir = ddr_reg;
    assign irq          = |pcif_reg;

endmodule

// File: tb/tb_gpio_port_pcint.sv
// Testbench for gpio_port_pcint: directed steps followed by random traffic on
// an 8-bit default instance, checked against a window-based reference model,
// plus directed checks on a 16-bit / 3-stage / unfiltered instance.
module tb_gpio_port_pcint;

    localparam int S = 2;
    localparam int F = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance
    logic [2:0] addr;
    logic       we, re;
    logic [7:0] wdata, rdata, pad, pout, pdir;
    logic       rvalid, irq;

    // Parametrised instance
    logic [2:0]  b_addr;
    logic        b_we, b_re;
    logic [15:0] b_wdata, b_rdata, b_pad, b_out, b_dir;
    logic        b_rvalid, b_irq;

    gpio_port_pcint dut (
        .clk(clk), .rst(rst), .bus_addr(addr), .bus_we(we), .bus_re(re),
        .bus_wdata(wdata), .bus_rdata(rdata), .bus_rvalid(rvalid),
        .gpio_pin_in(pad), .gpio_pin_out(pout), .gpio_pin_dir(pdir), .irq(irq)
    );

    gpio_port_pcint #(.WIDTH(16), .SYNC_STAGES(3), .FILTER_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .bus_addr(b_addr), .bus_we(b_we), .bus_re(b_re),
        .bus_wdata(b_wdata), .bus_rdata(b_rdata), .bus_rvalid(b_rvalid),
        .gpio_pin_in(b_pad), .gpio_pin_out(b_out), .gpio_pin_dir(b_dir), .irq(b_irq)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_filt, m_port, m_ddr, m_pcmsk, m_pcif, m_rdata;
    logic       m_rvalid;
    logic [7:0] pad_q[$];   // pad history still inside the synchroniser
    logic [7:0] win_q[$];   // last F synchronised samples

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] model_read(input logic [2:0] a);
        case (a)
            3'd0: return m_filt;
            3'd1: return m_ddr;
            3'd2: return m_port;
            3'd3: return m_pcmsk;
            3'd4: return m_pcif;
            default: return 8'h00;
        endcase
    endfunction

    // Filter rule as a sliding window: a bit flips once the last F
    // synchronised samples all disagree with the current filtered value.
    task automatic model_edge();
        logic [7:0] s, nf, clr;
        logic all_diff;
        if (rst) begin
            m_filt = 0; m_port = 0; m_ddr = 0; m_pcmsk = 0; m_pcif = 0;
            m_rdata = 0; m_rvalid = 0;
            pad_q.delete();
            win_q.delete();
            return;
        end
        if (re) m_rdata = model_read(addr);
        m_rvalid = re;
        pad_q.push_back(pad);
        s = 8'h00;
        if (pad_q.size() > S) s = pad_q.pop_front();
        win_q.push_back(s);
        if (win_q.size() > F) win_q.delete(0);
        nf = m_filt;
        if (win_q.size() == F) begin
            for (int i = 0; i < 8; i++) begin
                all_diff = 1'b1;
                foreach (win_q[k]) if (win_q[k][i] == m_filt[i]) all_diff = 1'b0;
                if (all_diff) nf[i] = ~m_filt[i];
            end
        end
        clr = (we && addr == 3'd4) ? wdata : 8'h00;
        m_pcif = (m_pcif & ~clr) | ((nf ^ m_filt) & m_pcmsk);
        if (we) begin
            case (addr)
                3'd0: m_port = m_port ^ wdata;
                3'd1: m_ddr = wdata;
                3'd2: m_port = wdata;
                3'd3: m_pcmsk = wdata;
                default: ;
            endcase
        end
        m_filt = nf;
    endtask

    task automatic compare_all();
        chk("gpio_pin_out", 32'(pout), 32'(m_port));
        chk("gpio_pin_dir", 32'(pdir), 32'(m_ddr));
        chk("irq", 32'(irq), 32'(|m_pcif));
        chk("bus_rvalid", 32'(rvalid), 32'(m_rvalid));
        chk("bus_rdata", 32'(rdata), 32'(m_rdata));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [7:0] d);
        addr = a; wdata = d; we = 1'b1;
        tick();
        we = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [7:0] d);
        addr = a; re = 1'b1;
        tick();
        re = 1'b0;
        chk("read_rvalid", 32'(rvalid), 32'd1);
        d = rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        addr = 0; we = 0; re = 0; wdata = 0; pad = 0;
        b_addr = 0; b_we = 0; b_re = 0; b_wdata = 0; b_pad = 0;

        // Power-on reset
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out", 32'(pout), 32'd0);
        chk("rst_dir", 32'(pdir), 32'd0);
        chk("rst_irq", 32'(irq), 32'd0);
        repeat (4) tick();

        // Register access
        bus_write(3'd1, 8'hFF);
        bus_write(3'd2, 8'hA5);
        bus_write(3'd0, 8'h0F);
        chk("pin_toggle_port", 32'(pout), 32'h0000_00AA);
        bus_read(3'd1, d); chk("rd_ddr", 32'(d), 32'h0000_00FF);
        tick(); chk("rvalid_drop", 32'(rvalid), 32'd0);
        bus_read(3'd2, d); chk("rd_port", 32'(d), 32'h0000_00AA);
        bus_read(3'd5, d); chk("rd_unused", 32'(d), 32'd0);
        tick();

        // Filter latency: filt flips on edge 6, so only the read sampled
        // on edge 7 or later sees it.
        pad = 8'h01;
        for (int k = 1; k <= 8; k++) begin
            addr = 3'd0; re = 1'b1;
            tick();
            chk("pin_latency", 32'(rdata[0]), (k >= 7) ? 32'd1 : 32'd0);
        end
        re = 1'b0;

        // Three-cycle pulse on bit 1 is rejected
        pad = 8'h03;
        repeat (3) tick();
        pad = 8'h01;
        for (int k = 0; k < 10; k++) begin
            addr = 3'd0; re = 1'b1;
            tick();
            chk("pulse_reject", 32'(rdata[1]), 32'd0);
        end
        re = 1'b0;

        // Pin-change interrupt on masked bit 0
        bus_write(3'd3, 8'h01);
        pad = 8'h00;
        repeat (8) tick();
        bus_read(3'd4, d); chk("pcif_set", 32'(d), 32'h1);
        chk("irq_set", 32'(irq), 32'd1);
        pad = 8'h04;
        repeat (8) tick();
        bus_read(3'd4, d); chk("pcif_unmasked", 32'(d), 32'h1);
        bus_write(3'd4, 8'h01);
        chk("irq_cleared", 32'(irq), 32'd0);

        // Set/clear collision: the clear lands on the toggle edge (edge 6)
        pad = 8'h05;
        repeat (5) tick();
        addr = 3'd4; wdata = 8'h01; we = 1'b1;
        tick();
        we = 1'b0;
        chk("collide_irq", 32'(irq), 32'd1);
        bus_read(3'd4, d); chk("collide_pcif", 32'(d[0]), 32'd1);

        // Asynchronous reset between edges
        addr = 3'd2; re = 1'b1;
        tick();
        re = 1'b0;
        pad = 8'h00;
        #2;
        rst = 1'b1;
        #1;
        chk("async_out", 32'(pout), 32'd0);
        chk("async_dir", 32'(pdir), 32'd0);
        chk("async_irq", 32'(irq), 32'd0);
        chk("async_rvalid", 32'(rvalid), 32'd0);
        tick();
        rst = 1'b0;
        repeat (6) tick();
        bus_read(3'd0, d); chk("pin_after_rst", 32'(d), 32'd0);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(3) == 0) pad = 8'($urandom);
            we    = ($urandom_range(3) == 0);
            re    = ($urandom_range(1) == 1);
            addr  = 3'($urandom_range(7));
            wdata = 8'($urandom);
            rst   = (n == 200);
            tick();
        end
        we = 0; re = 0; rst = 0;
        tick();

        // WIDTH=16, SYNC_STAGES=3, FILTER_CYCLES=1
        b_addr = 3'd3; b_wdata = 16'h8000; b_we = 1'b1;
        tick();
        b_we = 1'b0;
        repeat (6) tick();
        chk("b_irq_idle", 32'(b_irq), 32'd0);
        b_pad = 16'h8000;
        for (int k = 1; k <= 5; k++) begin
            b_addr = 3'd0; b_re = 1'b1;
            tick();
            chk("b_latency", 32'(b_rdata[15]), (k >= 5) ? 32'd1 : 32'd0);
        end
        chk("b_irq", 32'(b_irq), 32'd1);
        b_addr = 3'd4;
        tick();
        chk("b_pcif", 32'(b_rdata), 32'h0000_8000);
        b_re = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
